// File: rtl/chip8_exec_scheduler.sv
// Execution scheduler for the CHIP-8 core: turns 500 Hz ticks into one-instruction
// start pulses, handles FX0A key waits, debug run/step, and the 60 Hz DT/ST timers.
module chip8_exec_scheduler #(
  parameter int PEND_W      = 2,
  parameter int MAX_PENDING = 3,
  parameter int OVR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_tick,
  input  logic             timer_clk,
  input  logic             run,
  input  logic             step,
  input  logic             cpu_done,
  input  logic             cpu_wait_key,
  input  logic             key_pressed,
  input  logic [3:0]       key_code,
  input  logic             dt_we,
  input  logic [7:0]       dt_wdata,
  input  logic             st_we,
  input  logic [7:0]       st_wdata,
  output logic             cpu_start,
  output logic             busy,
  output logic             key_valid,
  output logic [3:0]       key_latched,
  output logic [7:0]       dt_value,
  output logic [7:0]       st_value,
  output logic             beep,
  output logic [OVR_W-1:0] overrun_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    EXEC,
    KEY_DOWN,
    KEY_UP
  } stateT;

  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [OVR_W-1:0]  OVR_SAT  = {OVR_W{1'b1}};
  localparam logic [OVR_W-1:0]  OVR_ONE  = OVR_W'(1);

  stateT             state;
  stateT             stateNext;
  logic [PEND_W-1:0] pendingCnt;
  logic [PEND_W-1:0] pendingNext;
  logic              issueFromQueue;
  logic              tickAccept;
  logic              keyWait;
  logic              overrunInc;
  logic              timerPrev;
  logic              timerEdge;

  // Ticks are only meaningful while free-running and not parked on a key wait.
  assign keyWait    = (state == KEY_DOWN) || (state == KEY_UP);
  assign tickAccept = instr_tick && run && !keyWait;
  assign timerEdge  = timer_clk && !timerPrev;

  assign cpu_start = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign beep      = (st_value != 8'd0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    stateNext      = state;
    issueFromQueue = 1'b0;
    case (state)
      IDLE: begin
        if (run && (pendingCnt != '0)) begin
          stateNext      = ISSUE;
          issueFromQueue = 1'b1;
        end else if (!run && step) begin
          stateNext = ISSUE;
        end
      end
      ISSUE:    stateNext = EXEC;
      EXEC: begin
        if (cpu_done) begin
          stateNext = IDLE;
        end else if (cpu_wait_key) begin
          stateNext = KEY_DOWN;
        end
      end
      KEY_DOWN: if (key_pressed) stateNext = KEY_UP;
      KEY_UP:   if (!key_pressed) stateNext = EXEC;
      default:  stateNext = IDLE;
    endcase
  end

  // A tick that coincides with a queue-driven issue nets to zero and never overruns.
  always_comb begin
    pendingNext = pendingCnt;
    overrunInc  = 1'b0;
    if (!run) begin
      pendingNext = '0;
    end else begin
      case ({tickAccept, issueFromQueue})
        2'b01: pendingNext = pendingCnt - PEND_ONE;
        2'b10: begin
          if (pendingCnt == PEND_MAX) begin
            overrunInc = 1'b1;
          end else begin
            pendingNext = pendingCnt + PEND_ONE;
          end
        end
        default: pendingNext = pendingCnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pendingCnt  <= '0;
      overrun_cnt <= '0;
      key_valid   <= 1'b0;
      key_latched <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state      <= stateNext;
      pendingCnt <= pendingNext;
      key_valid  <= (state == KEY_UP) && !key_pressed;
      if (overrunInc && (overrun_cnt != OVR_SAT)) begin
        overrun_cnt <= overrun_cnt + OVR_ONE;
      end
      if ((state == KEY_DOWN) && key_pressed) begin
        key_latched <= key_code;
      end
    end
  end

  // Previous timer_clk resets high so a level already high at release is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timerPrev <= 1'b1;
      dt_value  <= 8'd0;
      st_value  <= 8'd0;
    end else begin
      timerPrev <= timer_clk;
      if (dt_we) begin
        dt_value <= dt_wdata;
      end else if (timerEdge && (dt_value != 8'd0)) begin
        dt_value <= dt_value - 8'd1;
      end
      if (st_we) begin
        st_value <= st_wdata;
      end else if (timerEdge && (st_value != 8'd0)) begin
        st_value <= st_value - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_chip8_exec_scheduler.sv
// Directed bench for chip8_exec_scheduler: a cycle-level behavioural model compared
// every cycle, plus literal expectations at the points the scenarios call out.
module tb_chip8_exec_scheduler;

  localparam int MAXP = 3;
  localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_EXEC = 2, PH_KDOWN = 3, PH_KUP = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_tick, timer_clk, run, step, cpu_done, cpu_wait_key, key_pressed;
  logic [3:0] key_code;
  logic       dt_we, st_we;
  logic [7:0] dt_wdata, st_wdata;
  logic       cpu_start, busy, key_valid, beep;
  logic [3:0] key_latched;
  logic [7:0] dt_value, st_value, overrun_cnt;

  int vectors = 0;
  int miscompares = 0;
  int startCount = 0;
  int base;

  // Behavioural model state
  int mPhase = PH_IDLE;
  int mPend = 0;
  int mOvr = 0;
  int mDt = 0;
  int mSt = 0;
  int mKey = 0;
  bit mKeyValid = 1'b0;
  bit mPrev = 1'b1;

  chip8_exec_scheduler #(.PEND_W(2), .MAX_PENDING(MAXP), .OVR_W(8)) dut (
    .clk(clk), .reset(reset), .instr_tick(instr_tick), .timer_clk(timer_clk),
    .run(run), .step(step), .cpu_done(cpu_done), .cpu_wait_key(cpu_wait_key),
    .key_pressed(key_pressed), .key_code(key_code), .dt_we(dt_we), .dt_wdata(dt_wdata),
    .st_we(st_we), .st_wdata(st_wdata), .cpu_start(cpu_start), .busy(busy),
    .key_valid(key_valid), .key_latched(key_latched), .dt_value(dt_value),
    .st_value(st_value), .beep(beep), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    instr_tick = 1'b1;
    cyc(1);
    instr_tick = 1'b0;
  endtask

  task automatic done_pulse();
    cpu_done = 1'b1;
    cyc(1);
    cpu_done = 1'b0;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    cyc(1);
    step = 1'b0;
  endtask

  // Model: pending is a bounded ticket count, phase follows the instruction lifecycle.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mPhase    <= PH_IDLE;
      mPend     <= 0;
      mOvr      <= 0;
      mDt       <= 0;
      mSt       <= 0;
      mKey      <= 0;
      mKeyValid <= 1'b0;
      mPrev     <= 1'b1;
    end else begin : modelStep
      automatic bit keyWait = (mPhase == PH_KDOWN) || (mPhase == PH_KUP);
      automatic bit take    = (mPhase == PH_IDLE) && run && (mPend > 0);
      automatic bit accept  = instr_tick && run && !keyWait;
      automatic bit tEdge   = timer_clk && !mPrev;
      automatic int np      = mPend;
      if (take) np = np - 1;
      if (accept) begin
        if (np < MAXP) np = np + 1;
        else if (mOvr < 255) mOvr <= mOvr + 1;
      end
      mPend <= run ? np : 0;

      case (mPhase)
        PH_IDLE:  if (take || (!run && step)) mPhase <= PH_ISSUE;
        PH_ISSUE: mPhase <= PH_EXEC;
        PH_EXEC:  if (cpu_done) mPhase <= PH_IDLE; else if (cpu_wait_key) mPhase <= PH_KDOWN;
        PH_KDOWN: if (key_pressed) begin mPhase <= PH_KUP; mKey <= int'(key_code); end
        PH_KUP:   if (!key_pressed) mPhase <= PH_EXEC;
        default:  mPhase <= PH_IDLE;
      endcase
      mKeyValid <= (mPhase == PH_KUP) && !key_pressed;

      if (dt_we) mDt <= int'(dt_wdata);
      else if (tEdge && mDt > 0) mDt <= mDt - 1;
      if (st_we) mSt <= int'(st_wdata);
      else if (tEdge && mSt > 0) mSt <= mSt - 1;
      mPrev <= timer_clk;
    end
  end

  always @(negedge clk) begin
    check("cpu_start", 32'(cpu_start), 32'(mPhase == PH_ISSUE));
    check("busy", 32'(busy), 32'(mPhase != PH_IDLE));
    check("key_valid", 32'(key_valid), 32'(mKeyValid));
    check("key_latched", 32'(key_latched), mKey);
    check("dt_value", 32'(dt_value), mDt);
    check("st_value", 32'(st_value), mSt);
    check("beep", 32'(beep), 32'(mSt != 0));
    check("overrun_cnt", 32'(overrun_cnt), mOvr);
  end

  always @(negedge clk) if (cpu_start === 1'b1) startCount <= startCount + 1;

  initial begin
    instr_tick = 0; run = 0; step = 0; cpu_done = 0; cpu_wait_key = 0;
    key_pressed = 0; key_code = 0; dt_we = 0; st_we = 0; dt_wdata = 0; st_wdata = 0;
    timer_clk = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    cyc(3);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun_cnt), 0);
    check("rst_dt", 32'(dt_value), 0);
    reset = 1'b1;
    cyc(1);

    // timer_clk high at reset release must not count as an edge
    dt_we = 1; dt_wdata = 8'h01; cyc(1); dt_we = 0;
    cyc(3);
    check("dt_level_at_release", 32'(dt_value), 32'h01);
    timer_clk = 1'b0;
    cyc(2);

    // Single tick: start two cycles later, exactly once
    run = 1'b1;
    cyc(5);
    tick();
    check("s1_no_start_yet", 32'(cpu_start), 0);
    cyc(1);
    check("s1_start", 32'(cpu_start), 1);
    cyc(1);
    check("s1_start_once", 32'(cpu_start), 0);
    cyc(50);
    check("s1_busy_held", 32'(busy), 1);
    done_pulse();
    check("s1_busy_fall", 32'(busy), 0);

    // Busy CPU with five ticks: pending saturates at 3, two overruns
    tick();
    cyc(3);
    instr_tick = 1'b1; cyc(5); instr_tick = 1'b0;
    check("s2_overrun", 32'(overrun_cnt), 2);
    base = startCount;
    repeat (3) begin
      done_pulse();
      cyc(4);
    end
    check("s2_three_starts", startCount - base, 3);
    done_pulse();
    cyc(4);
    check("s2_no_fourth", startCount - base, 3);
    check("s2_idle", 32'(busy), 0);

    // FX0A key wait: press then release, ticks discarded
    tick();
    cyc(3);
    cpu_wait_key = 1'b1; cyc(1); cpu_wait_key = 1'b0;
    instr_tick = 1'b1; cyc(2); instr_tick = 1'b0;
    key_code = 4'hA; key_pressed = 1'b1; instr_tick = 1'b1;
    cyc(4);
    instr_tick = 1'b0; key_code = 4'h3;
    cyc(1);
    check("s3_no_valid_while_held", 32'(key_valid), 0);
    key_pressed = 1'b0;
    cyc(1);
    check("s3_key_valid", 32'(key_valid), 1);
    check("s3_key_latched", 32'(key_latched), 32'hA);
    cyc(1);
    check("s3_key_valid_once", 32'(key_valid), 0);
    check("s3_overrun_kept", 32'(overrun_cnt), 2);
    base = startCount;
    done_pulse();
    cyc(4);
    check("s3_no_pending", startCount - base, 0);

    // Sound timer: two edges, long high level counts once
    st_we = 1; st_wdata = 8'h02; cyc(1); st_we = 0;
    check("s4_st_load", 32'(st_value), 2);
    check("s4_beep_on", 32'(beep), 1);
    timer_clk = 1'b1; cyc(1);
    check("s4_st_edge1", 32'(st_value), 1);
    check("s4_dt_edge1", 32'(dt_value), 0);
    cyc(100);
    check("s4_level_once", 32'(st_value), 1);
    check("s4_beep_still", 32'(beep), 1);
    timer_clk = 1'b0; cyc(2); timer_clk = 1'b1; cyc(1);
    check("s4_st_edge2", 32'(st_value), 0);
    check("s4_beep_off", 32'(beep), 0);
    check("s4_dt_stays_zero", 32'(dt_value), 0);
    timer_clk = 1'b0; cyc(2); timer_clk = 1'b1; cyc(1);
    check("s4_st_no_wrap", 32'(st_value), 0);

    // Write in the same cycle as an edge wins
    timer_clk = 1'b0; cyc(2);
    timer_clk = 1'b1; dt_we = 1; dt_wdata = 8'h05; cyc(1); dt_we = 0;
    check("s5_dt_write_wins", 32'(dt_value), 5);
    timer_clk = 1'b0; cyc(2); timer_clk = 1'b1; cyc(1);
    check("s5_dt_dec", 32'(dt_value), 4);

    // Single-step debug control
    run = 1'b0;
    cyc(2);
    base = startCount;
    step_pulse();
    cyc(3);
    check("s6_one_step", startCount - base, 1);
    step_pulse();
    cyc(3);
    check("s6_step_busy_ignored", startCount - base, 1);
    done_pulse();
    cyc(2);
    run = 1'b1;
    step_pulse();
    cyc(3);
    check("s6_step_run_ignored", startCount - base, 1);

    // Dropping run mid-EXEC finishes the instruction then parks
    tick();
    cyc(3);
    run = 1'b0;
    tick();
    done_pulse();
    cyc(4);
    check("s6_parked", 32'(busy), 0);

    // Reset while in KEY_UP aborts with no key_valid
    step_pulse();
    cyc(3);
    cpu_wait_key = 1'b1; cyc(1); cpu_wait_key = 1'b0;
    key_code = 4'h5; key_pressed = 1'b1; cyc(1);
    check("s7_in_wait", 32'(busy), 1);
    reset = 1'b0;
    #1;
    check("s7_rst_busy", 32'(busy), 0);
    check("s7_rst_start", 32'(cpu_start), 0);
    check("s7_rst_key_valid", 32'(key_valid), 0);
    check("s7_rst_key_latched", 32'(key_latched), 0);
    check("s7_rst_dt", 32'(dt_value), 0);
    check("s7_rst_beep", 32'(beep), 0);
    check("s7_rst_overrun", 32'(overrun_cnt), 0);
    key_pressed = 1'b0;
    cyc(2);
    check("s7_no_valid_in_reset", 32'(key_valid), 0);
    reset = 1'b1;
    cyc(3);
    check("s7_after_busy", 32'(busy), 0);
    check("s7_after_key_valid", 32'(key_valid), 0);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chip8_exec_scheduler.md
Name: chip8_exec_scheduler

Overview:
- Sequences the CHIP-8 CPU core. Converts the 500 Hz instruction tick from the clock generator into one-instruction start pulses and buffers ticks that arrive while the CPU is busy.
- Handles FX0A key-wait stalls and run/single-step debug control.
- Owns the delay timer (DT) and sound timer (ST), which are decremented on rising edges of the 60 Hz vSync-derived timer clock.
- Sits between the clock generator, the CPU execute unit and the keypad/audio front end.

Parameters:
- PEND_W, 2, width of the pending instruction-tick counter.
- MAX_PENDING, 3, saturation value of the pending counter; must be ≤ 2^PEND_W−1.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- instr_tick  in  1  one-cycle pulse at 500 Hz from the clock generator.
- timer_clk  in  1  60 Hz level signal (vSync); only its rising edge is used.
- run  in  1  1 = free-running execution.
- step  in  1  one-cycle single-step request.
- cpu_done  in  1  one-cycle pulse: CPU finished the current instruction.
- cpu_wait_key  in  1  CPU is executing FX0A and needs a key.
- key_pressed  in  1  any keypad key held.
- key_code  in  4  index of the held key.
- dt_we  in  1  load DT (FX15).
- dt_wdata  in  8  DT load value.
- st_we  in  1  load ST (FX18).
- st_wdata  in  8  ST load value.
- cpu_start  out  1  one-cycle pulse: begin one instruction.
- busy  out  1  state ≠ IDLE.
- key_valid  out  1  one-cycle pulse: key_latched is valid for FX0A.
- key_latched  out  4  key captured during the wait.
- dt_value  out  8  current DT (FX07).
- st_value  out  8  current ST.
- beep  out  1  st_value ≠ 0.
- overrun_cnt  out  OVR_W  count of ticks dropped at saturation; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-low) clears:
  - all outputs to 0;
  - state to IDLE;
  - pending and overrun counters to 0.
- The timer_clk previous-value register resets to 1, so a high level at reset release is not counted as an edge.
- States are IDLE, ISSUE, EXEC, KEY_DOWN, KEY_UP.
- IDLE:
  - If run=1 and pending>0: go to ISSUE and decrement pending.
  - Else if run=0 and step=1: go to ISSUE; pending is untouched.
  - cpu_done is ignored in IDLE.
- ISSUE:
  - cpu_start=1 for exactly this cycle, then go to EXEC.
  - Latency from the tick to cpu_start is 2 cycles when idle with pending=0 (tick→pending, IDLE→ISSUE, cpu_start asserted).
- EXEC:
  - On cpu_done, go to IDLE.
  - Else if cpu_wait_key=1, go to KEY_DOWN.
  - If cpu_done and cpu_wait_key are both high in the same cycle, cpu_done wins.
- KEY_DOWN: when key_pressed=1, latch key_code into key_latched and go to KEY_UP.
- KEY_UP:
  - When key_pressed=0, pulse key_valid for one cycle and return to EXEC.
  - The CPU then completes and asserts cpu_done.
  - This implements press-then-release semantics.
- Pending counter:
  - instr_tick increments pending when run=1 and state is not KEY_DOWN or KEY_UP.
  - Ticks during a key wait are discarded and do not count as overrun.
  - A tick at pending=MAX_PENDING is dropped and overrun_cnt increments (saturating).
  - A tick in the same cycle as the IDLE→ISSUE decrement leaves pending unchanged (net +1−1).
  - When run=0, pending is forced to 0 and ticks are ignored.
- run and step:
  - Deasserting run mid-EXEC lets the current instruction finish, then the block stays in IDLE.
  - step while run=1 or while busy is ignored and not queued.
- Timers:
  - A timer edge is timer_clk=1 with the previous sample 0.
  - On a timer edge, each of DT and ST decrements if nonzero; 0 stays 0 with no wrap.
  - dt_we/st_we in the same cycle as an edge: the write wins and that timer is not decremented on that edge.
  - Timers run regardless of run, state or key wait.
  - beep is combinational from st_value.
- Reset mid-operation (including KEY_UP) aborts immediately to IDLE with no key_valid pulse.

Test Plan:
- run=1, single instr_tick at cycle 10 → cpu_start high at cycle 12 only. Hold cpu_done low 50 cycles, then pulse → busy falls next cycle.
- CPU held busy (no cpu_done), 5 instr_ticks → pending=3, overrun_cnt=2. Then 3 cpu_done pulses → 3 further cpu_starts; a 4th cpu_done → no cpu_start.
- In EXEC, assert cpu_wait_key, key_pressed=1 with key_code=0xA for 4 cycles, then release → key_valid pulses once with key_latched=0xA. Ticks during the wait leave pending and overrun_cnt unchanged.
- st_we with 0x02, then 2 timer_clk rising edges → beep=1 until the second edge, then 0. A level held high for 100 cycles counts once.
- dt_we with 0x05 in the same cycle as a timer edge → dt_value=0x05. Next edge → 0x04. DT at 0 with an edge → stays 0.
- run=0, step pulse → exactly one cpu_start. step during EXEC → ignored. Assert reset in KEY_UP → all outputs 0, state IDLE, no key_valid.
